// File: rtl/ahb2apb_pkg.sv
// Shared AHB-to-APB bridge definitions.
// Sequencer state encoding and width helpers.
package ahb2apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  function automatic int unsigned ratio_of(
    input int unsigned ahb_dw,
    input int unsigned apb_dw
  );
    return ahb_dw / apb_dw;
  endfunction

  function automatic int unsigned beat_w_of(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/apb_beat_cnt.sv
// APB beat index counter.
// Synchronous clear/increment with a last-beat flag.
module apb_beat_cnt #(
  parameter int unsigned RATIO = 4,
  parameter int unsigned BW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [BW-1:0] beat,
  output logic          last
);

  assign last = (beat == BW'(RATIO - 1));

  // Saturates at the last beat so the index can never wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      beat <= '0;
    end else if (inc && !last) begin
      beat <= beat + BW'(1);
    end
  end

endmodule

// File: rtl/apb_read_seq.sv
// APB read sequencer: splits one AHB-width read into
// RATIO APB read beats and strobes the HRDATA slices.
module apb_read_seq
  import ahb2apb_pkg::*;
#(
  parameter int unsigned AHB_DW = 32,
  parameter int unsigned APB_DW = 8,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned RATIO = ratio_of(AHB_DW, APB_DW),
  localparam int unsigned BW    = beat_w_of(RATIO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [RATIO-1:0]  o_load,
  output logic [ADDR_W-1:0] o_PADDR,
  output logic              o_PSEL,
  output logic              o_PENABLE,
  output logic              o_PWRITE,
  input  logic              i_PREADY,
  input  logic              i_PSLVERR
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(AHB_DW / 8 - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(APB_DW / 8);

  apb_state_e        state_q;
  apb_state_e        state_d;
  logic [ADDR_W-1:0] base_q;
  logic              err_q;
  logic              err_d;
  logic              cnt_clr;
  logic              cnt_inc;
  logic [BW-1:0]     beat;
  logic              last;
  logic              take;

  apb_beat_cnt #(
    .RATIO (RATIO),
    .BW    (BW)
  ) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .beat (beat),
    .last (last)
  );

  assign take = (state_q == ST_IDLE) && i_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (take) begin
        base_q <= i_addr & ~LOW_MASK;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    o_err     = 1'b0;
    o_load    = '0;
    o_PSEL    = 1'b0;
    o_PENABLE = 1'b0;
    o_PADDR   = '0;
    o_PWRITE  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_d = ST_SETUP;
          err_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      ST_SETUP: begin
        o_PSEL  = 1'b1;
        o_PADDR = base_q + ADDR_W'(beat) * STEP;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        o_PSEL    = 1'b1;
        o_PENABLE = 1'b1;
        o_PADDR   = base_q + ADDR_W'(beat) * STEP;
        if (i_PREADY) begin
          if (i_PSLVERR) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            o_load = RATIO'(1) << beat;
            if (last) begin
              state_d = ST_DONE;
              err_d   = 1'b0;
            end else begin
              state_d = ST_SETUP;
              cnt_inc = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        o_err   = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/apb_read_seq.md
APB_READ_SEQ -- requirements
Module: apb_read_seq

Interface
REQ-001 SHALL have parameter AHB_DW, default 32: AHB data width in bits.
REQ-002 SHALL have parameter APB_DW, default 8: APB data width in bits; RATIO = AHB_DW/APB_DW, an integer >= 1.
REQ-003 SHALL have parameter ADDR_W, default 32: address width in bits.
REQ-004 SHALL have port clk  in  1  the single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port i_start  in  1  request for one AHB-width read; sampled only in IDLE.
REQ-007 SHALL have port i_addr  in  ADDR_W  AHB read address; sampled with i_start.
REQ-008 SHALL have port o_busy  out  1  high in every state except IDLE.
REQ-009 SHALL have port o_done  out  1  one-cycle pulse at sequence end.
REQ-010 SHALL have port o_err  out  1  valid with o_done; 1 = sequence aborted on PSLVERR.
REQ-011 SHALL have port o_load  out  RATIO  one-hot load strobes to the HRDATA register slices.
REQ-012 SHALL have ports o_PADDR (ADDR_W), o_PSEL (1), o_PENABLE (1), o_PWRITE (1): outputs, APB master request.
REQ-013 SHALL have ports i_PREADY (1), i_PSLVERR (1): inputs, APB completer response.

Function
REQ-014 SHALL implement the states IDLE, SETUP, ACCESS, DONE.
REQ-015 SHALL go IDLE->SETUP on the edge where i_start=1, latching base = i_addr with its low log2(AHB_DW/8) bits forced to 0, and clearing the beat index.
REQ-016 SHALL ignore i_start outside IDLE, with no queuing.
REQ-017 SHALL drive o_PSEL=1, o_PENABLE=0 in SETUP, then go SETUP->ACCESS unconditionally.
REQ-018 SHALL drive o_PSEL=1, o_PENABLE=1 in ACCESS and remain in ACCESS while i_PREADY=0, holding o_PADDR, o_PSEL and o_PENABLE stable.
REQ-019 SHALL drive o_PADDR = base + beat*(APB_DW/8) in SETUP and ACCESS, and 0 otherwise.
REQ-020 SHALL hold o_PWRITE at 0 at all times.
REQ-021 SHALL drive o_load[beat]=1 combinationally in the ACCESS cycle where i_PREADY=1 and i_PSLVERR=0, so the slice captures PRDATA on that edge; o_load SHALL be 0 at all other times.
REQ-022 SHALL, on an ACCESS cycle with i_PREADY=1, i_PSLVERR=0 and beat<RATIO-1, increment beat and go to SETUP with no idle cycle.
REQ-023 SHALL, on an ACCESS cycle with i_PREADY=1, i_PSLVERR=0 and beat=RATIO-1, go to DONE with the error flag = 0.
REQ-024 SHALL, on an ACCESS cycle with i_PREADY=1 and i_PSLVERR=1, assert no o_load, abort the remaining beats, and go to DONE with the error flag = 1.
REQ-025 SHALL, in DONE, drive o_done=1 and o_err = error flag for exactly one cycle, then return to IDLE; i_start in DONE SHALL be ignored.
REQ-026 SHALL complete a zero-wait sequence in 2*RATIO+1 cycles after the i_start edge; each wait cycle SHALL add one cycle.
REQ-027 SHALL support RATIO=1 as a single-beat sequence.
REQ-028 SHALL size the beat index to max(1, clog2(RATIO)) bits; the index never wraps, because it only advances when beat<RATIO-1.
REQ-029 SHALL ignore i_PREADY and i_PSLVERR outside ACCESS.

Reset
REQ-030 SHALL, with rst=1 at an edge, enter IDLE and clear base, beat and the error flag, whatever the current state, including mid-ACCESS.
REQ-031 SHALL reset outputs to o_busy=0, o_done=0, o_err=0, o_load=0, o_PSEL=0, o_PENABLE=0, o_PADDR=0, o_PWRITE=0.
REQ-032 SHALL let rst override i_start presented in the same cycle.

Structure
REQ-033 SHALL take the state encoding (IDLE=0, SETUP=1, ACCESS=2, DONE=3) and the RATIO/beat-width derivation from the shared ahb2apb package, for use by other bridge blocks.
REQ-034 SHALL contain one sub-module, apb_beat_cnt: a synchronous clear/increment beat counter with a last-beat flag.
REQ-035 SHALL contain no data path; the parent connects o_load to the HRDATA register slices.

Verification
REQ-036 SHALL cover: AHB_DW=32, APB_DW=8, i_addr=0x1003, zero-wait slave -> PADDR 0x1000/0x1001/0x1002/0x1003, o_load 0001/0010/0100/1000, o_done at cycle 9, o_err=0.
REQ-037 SHALL cover: the same request with 2 wait cycles on beat 2 -> PADDR 0x1002 and PSEL/PENABLE held for 3 ACCESS cycles, o_done at cycle 11.
REQ-038 SHALL cover: PSLVERR=1 with PREADY on beat 1 -> o_load[1] never asserted, no beats 2-3, o_done at cycle 5 with o_err=1.
REQ-039 SHALL cover: i_start pulsed during ACCESS and during DONE -> ignored; exactly one o_done per accepted start.
REQ-040 SHALL cover: rst=1 during ACCESS of beat 2 -> next cycle IDLE with all outputs 0; a new start runs a full sequence from beat 0.
REQ-041 SHALL cover: AHB_DW=APB_DW=32, i_start with i_addr=0x20 -> single beat, o_load=1, o_done at cycle 3.
